// File: rtl/slot_pin_mux.sv
// Per-slot pad multiplexer: maps CS/dig-out/PWM/phase/UART onto slot pads by type code, with quiesce-on-reconfig.
// Latency: internal inputs -> pads 1 cycle; pads -> pin_in SYNC_STAGES; pads -> UC_RXD0 SYNC_STAGES+1.
// No backpressure: purely combinational routing plus registered outputs, every cycle.

`ifndef M_DIR_OUT
`define M_DIR_OUT 1'b1
`endif
`ifndef M_DIR_IN
`define M_DIR_IN 1'b0
`endif
`ifndef DEV_TYPE_STEPPER
`define DEV_TYPE_STEPPER 8'h01
`endif
`ifndef DEV_TYPE_SERVO
`define DEV_TYPE_SERVO 8'h02
`endif
`ifndef DEV_TYPE_OTM_DAC
`define DEV_TYPE_OTM_DAC 8'h03
`endif
`ifndef DEV_TYPE_RS232
`define DEV_TYPE_RS232 8'h04
`endif

module slot_pin_mux #(
    parameter int NUM_SLOTS              = 7,
    parameter int NUM_IO_PINS_PER_SLOT   = 10,
    parameter int SLOT_TYPE_CONFIG_WIDTH = 8,
    parameter int NUM_CS_PER_SLOT        = 2,
    parameter int NUM_DIG_OUT_PER_SLOT   = 2,
    parameter int NUM_INTRPTS_PER_SLOT   = 3,
    parameter int SYNC_STAGES            = 2,
    parameter int SETTLE_CYCLES          = 16,
    parameter int DEBOUNCE_CYCLES        = 8
) (
    input  logic                                               clk,
    input  logic                                               resetn,
    input  logic [NUM_SLOTS*SLOT_TYPE_CONFIG_WIDTH-1:0]        slot_type_config,
    input  logic [NUM_SLOTS*NUM_CS_PER_SLOT-1:0]               cs_decoded,
    input  logic [NUM_SLOTS*NUM_DIG_OUT_PER_SLOT-1:0]          dig_out,
    input  logic [NUM_SLOTS-1:0]                               pwm_out,
    input  logic [NUM_SLOTS-1:0]                               servo_phase,
    input  logic [NUM_SLOTS*NUM_IO_PINS_PER_SLOT-1:0]          pin_in_raw,
    input  logic                                               UC_TXD0,
    output logic [NUM_SLOTS*NUM_IO_PINS_PER_SLOT-1:0]          pin_io_dir,
    output logic [NUM_SLOTS*NUM_IO_PINS_PER_SLOT-1:0]          pin_out,
    output logic [NUM_SLOTS*NUM_IO_PINS_PER_SLOT-1:0]          pin_in,
    output logic [NUM_SLOTS*NUM_INTRPTS_PER_SLOT-1:0]          pin_intrpt,
    output logic                                               UC_RXD0,
    output logic [NUM_SLOTS-1:0]                               slot_ready
);

    localparam int NS  = NUM_SLOTS;
    localparam int NP  = NUM_IO_PINS_PER_SLOT;
    localparam int SW  = SLOT_TYPE_CONFIG_WIDTH;
    localparam int NCS = NUM_CS_PER_SLOT;
    localparam int NDO = NUM_DIG_OUT_PER_SLOT;
    localparam int NI  = NUM_INTRPTS_PER_SLOT;
    localparam int CW  = $clog2(SETTLE_CYCLES + 1);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SW-1:0] T_STEPPER = SW'(`DEV_TYPE_STEPPER);
    localparam logic [SW-1:0] T_SERVO   = SW'(`DEV_TYPE_SERVO);
    localparam logic [SW-1:0] T_OTM_DAC = SW'(`DEV_TYPE_OTM_DAC);
    localparam logic [SW-1:0] T_RS232   = SW'(`DEV_TYPE_RS232);

    typedef enum logic {QUIESCE = 1'b0, ACTIVE = 1'b1} state_t;

    function automatic logic known_type(input logic [SW-1:0] t);
        return (t == T_STEPPER) || (t == T_SERVO) || (t == T_OTM_DAC) || (t == T_RS232);
    endfunction

    // Only cs[0] of each slot is routed by any map; the other selects are intentionally unused.
    logic cs_unused;
    assign cs_unused = ^cs_decoded;

    logic [NS*NP-1:0] sync_q [SYNC_STAGES];
    state_t           state_q [NS];
    state_t           state_d [NS];
    logic [CW-1:0]    cnt_q [NS];
    logic [CW-1:0]    cnt_d [NS];
    logic [SW-1:0]    type_q [NS];
    logic [SW-1:0]    cfg [NS];
    logic [DW-1:0]    deb_q [NS*NI];
    logic [NS*NP-1:0] dir_d;
    logic [NS*NP-1:0] out_d;
    logic [NS*NI-1:0] src;
    logic [NS-1:0]    owner;
    logic             rxd_d;

    // Pad input synchroniser chain; the last stage is the published pin_in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_in_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign pin_in = sync_q[SYNC_STAGES-1];

    // Slot FSM next state: any type change drops to QUIESCE at once and restarts the settle count.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            cfg[s]     = slot_type_config[s*SW +: SW];
            state_d[s] = state_q[s];
            cnt_d[s]   = cnt_q[s];
            if (cfg[s] != type_q[s]) begin
                state_d[s] = QUIESCE;
                cnt_d[s]   = '0;
            end else if (state_q[s] == QUIESCE) begin
                if (cnt_q[s] == CW'(SETTLE_CYCLES - 1)) begin
                    if (known_type(cfg[s])) state_d[s] = ACTIVE;
                end else begin
                    cnt_d[s] = cnt_q[s] + CW'(1);
                end
            end
        end
    end

    // UART owner: the lowest-index slot that will be ACTIVE this cycle with a UART-capable type.
    always_comb begin
        logic taken;
        taken = 1'b0;
        owner = '0;
        for (int s = 0; s < NS; s++) begin
            if (!taken && state_d[s] == ACTIVE && (cfg[s] == T_STEPPER || cfg[s] == T_RS232)) begin
                owner[s] = 1'b1;
                taken    = 1'b1;
            end
        end
    end

    // Pad map for every ACTIVE slot; everything else defaults to input, driven low, interrupt idle.
    always_comb begin
        dir_d = {(NS*NP){`M_DIR_IN}};
        out_d = '0;
        src   = '1;
        rxd_d = 1'b1;
        for (int s = 0; s < NS; s++) begin
            if (state_d[s] == ACTIVE) begin
                case (cfg[s])
                    T_STEPPER: begin
                        dir_d[s*NP+0] = `M_DIR_OUT;
                        out_d[s*NP+0] = owner[s] ? UC_TXD0 : 1'b1;
                        dir_d[s*NP+1] = `M_DIR_OUT;
                        out_d[s*NP+1] = dig_out[s*NDO+0];
                        dir_d[s*NP+6] = `M_DIR_OUT;
                        out_d[s*NP+6] = cs_decoded[s*NCS+0];
                        src[s*NI+0]   = pin_in[s*NP+2];
                        src[s*NI+1]   = pin_in[s*NP+3];
                        src[s*NI+2]   = pin_in[s*NP+4];
                        if (owner[s]) rxd_d = pin_in[s*NP+5];
                    end
                    T_SERVO: begin
                        dir_d[s*NP+0] = `M_DIR_OUT;
                        out_d[s*NP+0] = dig_out[s*NDO+0];
                        dir_d[s*NP+4] = `M_DIR_OUT;
                        out_d[s*NP+4] = dig_out[s*NDO+1];
                        dir_d[s*NP+5] = `M_DIR_OUT;
                        out_d[s*NP+5] = servo_phase[s];
                        dir_d[s*NP+7] = `M_DIR_OUT;
                        out_d[s*NP+7] = pwm_out[s];
                        src[s*NI+0]   = pin_in[s*NP+1];
                    end
                    T_OTM_DAC: begin
                        dir_d[s*NP+0] = `M_DIR_OUT;
                        out_d[s*NP+0] = cs_decoded[s*NCS+0];
                        dir_d[s*NP+7] = `M_DIR_OUT;
                        out_d[s*NP+7] = dig_out[s*NDO+0];
                    end
                    T_RS232: begin
                        dir_d[s*NP+0] = `M_DIR_OUT;
                        out_d[s*NP+0] = owner[s] ? UC_TXD0 : 1'b1;
                        if (owner[s]) rxd_d = pin_in[s*NP+1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Slot state and registered pad outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pin_io_dir <= {(NS*NP){`M_DIR_IN}};
            pin_out    <= '0;
            UC_RXD0    <= 1'b1;
            slot_ready <= '0;
            for (int s = 0; s < NS; s++) begin
                state_q[s] <= QUIESCE;
                cnt_q[s]   <= '0;
                type_q[s]  <= '0;
            end
        end else begin
            pin_io_dir <= dir_d;
            pin_out    <= out_d;
            UC_RXD0    <= rxd_d;
            for (int s = 0; s < NS; s++) begin
                state_q[s]    <= state_d[s];
                cnt_q[s]      <= cnt_d[s];
                type_q[s]     <= cfg[s];
                slot_ready[s] <= (state_d[s] == ACTIVE);
            end
        end
    end

    // Interrupt debounce: output flips only after the source has disagreed for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pin_intrpt <= '1;
            for (int k = 0; k < NS*NI; k++) deb_q[k] <= '0;
        end else begin
            for (int k = 0; k < NS*NI; k++) begin
                if (state_d[k/NI] != ACTIVE) begin
                    pin_intrpt[k] <= 1'b1;
                    deb_q[k]      <= '0;
                end else if (src[k] == pin_intrpt[k]) begin
                    deb_q[k] <= '0;
                end else if (deb_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    pin_intrpt[k] <= ~pin_intrpt[k];
                    deb_q[k]      <= '0;
                end else begin
                    deb_q[k] <= deb_q[k] + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_slot_pin_mux.sv
// Bench for slot_pin_mux: directed phases with randomized data against a behavioural slot/pad model.
// Latency: outputs sampled 1 time unit after each rising edge, model advanced once per edge.
// No backpressure involved; every step is a single clock.

module tb_slot_pin_mux;

    localparam int NS = 7, NP = 10, SW = 8, NCS = 2, NDO = 2, NI = 3;
    localparam int SETTLE = 16, DEB = 8;
    localparam logic [7:0] T_ST = 8'h01, T_SV = 8'h02, T_OD = 8'h03, T_RS = 8'h04;

    logic clk = 1'b0;
    logic resetn;
    logic [NS*SW-1:0]  cfg;
    logic [NS*NCS-1:0] cs;
    logic [NS*NDO-1:0] dout;
    logic [NS-1:0]     pwm, ph;
    logic [NS*NP-1:0]  raw;
    logic              txd;
    logic [NS*NP-1:0]  dir, pout, pin;
    logic [NS*NI-1:0]  intr;
    logic              rxd;
    logic [NS-1:0]     ready;

    int total = 0;
    int bad   = 0;
    string phase = "init";

    // reference model state
    int               stable [NS];
    logic [7:0]       prev_t [NS];
    logic [NS*NP-1:0] m_s1, m_pin;
    logic [NS*NI-1:0] m_intr;
    int               run [NS*NI];
    logic [NS*NP-1:0] e_dir, e_out;
    logic             e_rxd;
    logic [NS-1:0]    e_ready;

    always #5 clk = ~clk;

    slot_pin_mux dut (
        .clk(clk), .resetn(resetn), .slot_type_config(cfg), .cs_decoded(cs), .dig_out(dout),
        .pwm_out(pwm), .servo_phase(ph), .pin_in_raw(raw), .UC_TXD0(txd),
        .pin_io_dir(dir), .pin_out(pout), .pin_in(pin), .pin_intrpt(intr),
        .UC_RXD0(rxd), .slot_ready(ready)
    );

    task automatic chk(input string what, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s/%s got=%h exp=%h", phase, what, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin stable[s] = 0; prev_t[s] = 8'h00; end
        for (int k = 0; k < NS*NI; k++) run[k] = 0;
        m_s1 = '0; m_pin = '0; m_intr = '1;
        e_dir = '0; e_out = '0; e_rxd = 1'b1; e_ready = '0;
    endtask

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_edge();
        logic [NS*NP-1:0] old_pin;
        logic [NS*NI-1:0] src;
        bit               act [NS];
        int               owner, b;
        logic [7:0]       t;
        old_pin = m_pin; owner = -1; src = '1; e_dir = '0; e_out = '0;
        for (int s = 0; s < NS; s++) begin
            t = cfg[s*SW +: SW];
            if (t == prev_t[s]) begin
                if (stable[s] < 100000) stable[s]++;
            end else stable[s] = 0;
            prev_t[s]  = t;
            act[s]     = (t inside {T_ST, T_SV, T_OD, T_RS}) && (stable[s] >= SETTLE);
            e_ready[s] = act[s];
            if (act[s] && (t == T_ST || t == T_RS) && owner < 0) owner = s;
        end
        for (int s = 0; s < NS; s++) begin
            b = s*NP;
            t = prev_t[s];
            if (act[s]) begin
                case (t)
                    T_ST: begin
                        e_dir[b] = 1'b1; e_out[b] = (owner == s) ? txd : 1'b1;
                        e_dir[b+1] = 1'b1; e_out[b+1] = dout[s*NDO];
                        e_dir[b+6] = 1'b1; e_out[b+6] = cs[s*NCS];
                        src[s*NI +: 3] = old_pin[b+2 +: 3];
                    end
                    T_SV: begin
                        e_dir[b] = 1'b1;   e_out[b]   = dout[s*NDO];
                        e_dir[b+4] = 1'b1; e_out[b+4] = dout[s*NDO+1];
                        e_dir[b+5] = 1'b1; e_out[b+5] = ph[s];
                        e_dir[b+7] = 1'b1; e_out[b+7] = pwm[s];
                        src[s*NI] = old_pin[b+1];
                    end
                    T_OD: begin
                        e_dir[b] = 1'b1;   e_out[b]   = cs[s*NCS];
                        e_dir[b+7] = 1'b1; e_out[b+7] = dout[s*NDO];
                    end
                    default: begin
                        e_dir[b] = 1'b1; e_out[b] = (owner == s) ? txd : 1'b1;
                    end
                endcase
            end
        end
        e_rxd = (owner < 0) ? 1'b1 : old_pin[owner*NP + ((prev_t[owner] == T_ST) ? 5 : 1)];
        for (int k = 0; k < NS*NI; k++) begin
            if (!act[k/NI]) begin
                m_intr[k] = 1'b1; run[k] = 0;
            end else if (src[k] != m_intr[k]) begin
                run[k]++;
                if (run[k] == DEB) begin m_intr[k] = ~m_intr[k]; run[k] = 0; end
            end else run[k] = 0;
        end
        m_pin = m_s1;
        m_s1  = raw;
    endtask

    task automatic step();
        @(posedge clk); #1;
        model_edge();
        chk("dir", dir, e_dir);
        chk("out", pout, e_out);
        chk("pin_in", pin, m_pin);
        chk("intr", intr, m_intr);
        chk("rxd", rxd, e_rxd);
        chk("ready", ready, e_ready);
    endtask

    task automatic chk_reset();
        chk("rst_dir", dir, 70'h0);
        chk("rst_out", pout, 70'h0);
        chk("rst_pin_in", pin, 70'h0);
        chk("rst_intr", intr, 21'h1FFFFF);
        chk("rst_rxd", rxd, 1'b1);
        chk("rst_ready", ready, 7'h0);
    endtask

    task automatic rnd_int();
        cs = 14'($urandom()); dout = 14'($urandom());
        pwm = 7'($urandom()); ph = 7'($urandom()); txd = 1'($urandom());
    endtask

    task automatic set_type(input int s, input logic [7:0] t);
        cfg[s*SW +: SW] = t;
    endtask

    initial begin
        logic [7:0] tl [6];
        int lowcnt;
        tl = '{8'h00, T_ST, T_SV, T_OD, T_RS, 8'h55};
        resetn = 1'b0; cfg = '0; cs = '0; dout = '0; pwm = '0; ph = '0; raw = '0; txd = 1'b0;
        set_type(0, T_ST);
        model_reset();
        #12;
        phase = "reset";
        chk_reset();
        @(posedge clk); #3; resetn = 1'b1;

        phase = "stepper_bringup";
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 16) chk("ready0_before", ready[0], 1'b0);
            if (i == 17) chk("ready0_rise", ready[0], 1'b1);
            rnd_int(); raw = 70'({$urandom(), $urandom(), $urandom()});
        end

        phase = "servo_to_dac";
        set_type(2, T_SV);
        for (int i = 0; i < 20; i++) begin step(); rnd_int(); end
        set_type(2, T_OD);
        step();
        chk("slot2_dir_quiesce", dir[29:20], 10'h0);
        chk("slot2_out_quiesce", pout[29:20], 10'h0);
        for (int i = 2; i <= 18; i++) begin
            rnd_int(); step();
            if (i == 16) chk("ready2_before", ready[2], 1'b0);
            if (i == 17) chk("ready2_rise", ready[2], 1'b1);
        end

        phase = "toggle";
        set_type(4, T_ST);
        for (int i = 0; i < 5; i++) begin step(); rnd_int(); end
        set_type(4, T_SV);
        for (int i = 0; i < 5; i++) begin step(); rnd_int(); end
        set_type(4, T_ST);
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 16) chk("ready4_before", ready[4], 1'b0);
            if (i == 17) chk("ready4_rise", ready[4], 1'b1);
            rnd_int();
        end

        phase = "uart";
        set_type(0, T_SV);
        set_type(1, T_RS);
        set_type(3, T_ST);
        for (int i = 0; i < 17; i++) begin step(); rnd_int(); raw = 70'({$urandom(), $urandom(), $urandom()}); end
        for (int i = 0; i < 20; i++) begin
            step();
            chk("slot3_tx_idle", pout[30], 1'b1);
            rnd_int(); raw = 70'({$urandom(), $urandom(), $urandom()});
        end
        set_type(1, 8'h00);
        for (int i = 0; i < 20; i++) begin step(); rnd_int(); raw = 70'({$urandom(), $urandom(), $urandom()}); end

        phase = "debounce";
        set_type(0, T_ST);
        raw = '1;
        for (int i = 0; i < 20; i++) begin step(); rnd_int(); end
        raw[2] = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 7; i++) begin step(); rnd_int(); end
        raw[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin step(); if (intr[0] == 1'b0) lowcnt++; rnd_int(); end
        chk("short_pulse_low_cycles", lowcnt, 0);
        raw[2] = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 12; i++) begin step(); if (intr[0] == 1'b0) lowcnt++; rnd_int(); end
        raw[2] = 1'b1;
        for (int i = 0; i < 25; i++) begin step(); if (intr[0] == 1'b0) lowcnt++; rnd_int(); end
        chk("long_pulse_low_cycles", lowcnt, 12);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step();
            rnd_int();
            if ($urandom_range(0, 39) == 0) set_type($urandom_range(0, NS-1), tl[$urandom_range(0, 5)]);
            if ($urandom_range(0, 2) == 0) raw[$urandom_range(0, NS*NP-1)] ^= 1'b1;
        end

        phase = "async_reset";
        set_type(0, T_ST); set_type(2, T_SV); set_type(5, T_RS);
        for (int i = 0; i < 20; i++) begin step(); rnd_int(); end
        chk("three_active", {ready[0], ready[2], ready[5]}, 3'b111);
        #2; resetn = 1'b0; #1;
        chk_reset();
        model_reset();
        @(posedge clk); #3; resetn = 1'b1;
        phase = "after_reset";
        for (int i = 0; i < 20; i++) begin step(); rnd_int(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
